div_sequencer: RTL

//  Controller that sequences the shared iterative Division unit for the CPU's DIV/DIVU instructions.

---
 rtl/div_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Sequencer for the shared iterative divider: takes one DIV/DIVU op, feeds the
// divider unsigned magnitudes, waits out its latency and writes signed-corrected HI/LO.
module div_sequencer #(
  parameter int DIV_LATENCY = 32,
  parameter int WIDTH       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Magnitude of a two's-complement value; 0x80..0 maps to itself as unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? (W_ZERO - x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (W_ZERO - x) : x;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_accept;
  logic             w_b_zero;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div_start;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush beats accept in IDLE and is ignored in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_b_zero ? S_DONE : S_START;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_START: w_next = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (r_cnt == CNT_ZERO) begin
          w_next = S_FIX;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake decode from the current state
  always_comb begin
    w_ready  = (r_state == S_IDLE);
    w_accept = w_ready & op_valid & ~flush;
    w_b_zero = (op_b == W_ZERO);
  end

  // Operand capture, latency counter, result write and registered strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt       <= CNT_ZERO;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div_start <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_div_a     <= W_ZERO;
      r_div_b     <= W_ZERO;
      r_hi        <= W_ZERO;
      r_lo        <= W_ZERO;
    end else begin
      r_div_start <= (w_next == S_START);
      r_done      <= (w_next == S_DONE);
      r_div_zero  <= w_accept & w_b_zero;
      if (w_accept) begin
        r_sign_q <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        r_sign_r <= op_signed & op_a[WIDTH-1];
        r_div_a  <= f_mag(op_a, op_signed);
        r_div_b  <= f_mag(op_b, op_signed);
        if (w_b_zero) begin
          r_lo <= W_ONES;
          r_hi <= op_a;
        end
      end
      if (r_state == S_START) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == S_WAIT && r_cnt != CNT_ZERO) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (r_state == S_FIX && !flush) begin
        r_lo <= f_apply_sign(div_q, r_sign_q);
        r_hi <= f_apply_sign(div_r, r_sign_r);
      end
    end
  end

  assign op_ready  = w_ready;
  assign busy      = ~w_ready;
  assign div_start = r_div_start;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
